// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - MIPS write-back stage: WB mux, 32x32 register file, retire counter, RF dump sequencer
//
// Ports:
//   i_clock, i_reset                    clock, asynchronous active-high reset
//   i_mem_data, i_alu_result            MEM/WB latched write-back candidates
//   i_rf_wr_enb, i_rf_wr_data_src,
//   i_rf_wr_addr, i_valid               MEM/WB latched write control
//   i_rd_addr_a/b, o_rd_data_a/b        ID-stage combinational read ports
//   o_wb_data, o_wb_addr, o_wb_enb      write-back forwarding to EX
//   o_retired_count                     saturating retired-instruction count
//   i_dump_start, i_dump_ready,
//   o_dump_valid/addr/data/busy/done    handshaked register-file dump
//
// Build option: define WB_BYPASS_EN to make reads (and dump data) see a
// same-cycle write to the same register; otherwise reads return the stored value.

module writeback_unit #(
  parameter int NB_ADDR   = 5,
  parameter int NB_DATA   = 2**NB_ADDR,
  parameter int NB_RETIRE = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_mem_data,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_rf_wr_enb,
  input  logic                 i_rf_wr_data_src,
  input  logic [NB_ADDR-1:0]   i_rf_wr_addr,
  input  logic                 i_valid,
  input  logic [NB_ADDR-1:0]   i_rd_addr_a,
  input  logic [NB_ADDR-1:0]   i_rd_addr_b,
  output logic [NB_DATA-1:0]   o_rd_data_a,
  output logic [NB_DATA-1:0]   o_rd_data_b,
  output logic [NB_DATA-1:0]   o_wb_data,
  output logic [NB_ADDR-1:0]   o_wb_addr,
  output logic                 o_wb_enb,
  output logic [NB_RETIRE-1:0] o_retired_count,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic                 o_dump_valid,
  output logic [NB_ADDR-1:0]   o_dump_addr,
  output logic [NB_DATA-1:0]   o_dump_data,
  output logic                 o_dump_busy,
  output logic                 o_dump_done
);

  localparam int NREG = 2**NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  logic [NB_DATA-1:0]   rf_q [NREG];
  logic [NB_RETIRE-1:0] retired_q, retired_d;
  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic                 hit_a, hit_b, hit_dump;

  // Write-back select and forwarding qualifier
  assign o_wb_data = i_rf_wr_data_src ? i_mem_data : i_alu_result;
  assign o_wb_addr = i_rf_wr_addr;
  assign o_wb_enb  = i_valid & i_rf_wr_enb & (i_rf_wr_addr != '0);

  // Register file; r0 is never written because o_wb_enb excludes address 0
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (o_wb_enb) begin
      rf_q[i_rf_wr_addr] <= o_wb_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through: a read of the register being written sees the new value
  assign hit_a    = o_wb_enb && (i_rd_addr_a == i_rf_wr_addr);
  assign hit_b    = o_wb_enb && (i_rd_addr_b == i_rf_wr_addr);
  assign hit_dump = o_wb_enb && (addr_q == i_rf_wr_addr);
`else
  assign hit_a    = 1'b0;
  assign hit_b    = 1'b0;
  assign hit_dump = 1'b0;
`endif

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : (hit_a ? o_wb_data : rf_q[i_rd_addr_a]);
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : (hit_b ? o_wb_data : rf_q[i_rd_addr_b]);
  assign o_dump_data = (addr_q == '0) ? '0 : (hit_dump ? o_wb_data : rf_q[addr_q]);

  // Retire counter: every real instruction, saturating at all-ones
  always_comb begin
    retired_d = retired_q;
    if (i_valid && (retired_q != {NB_RETIRE{1'b1}})) retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) retired_q <= '0;
    else         retired_q <= retired_d;
  end

  assign o_retired_count = retired_q;

  // Dump FSM: state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Dump FSM: next state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (i_dump_start) state_d = SEND;
      end
      SEND: begin
        if (i_dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Dump FSM: outputs
  always_comb begin
    o_dump_valid = 1'b0;
    o_dump_busy  = 1'b0;
    o_dump_done  = 1'b0;
    case (state_q)
      SEND: begin
        o_dump_valid = 1'b1;
        o_dump_busy  = 1'b1;
      end
      DONE: begin
        o_dump_done = 1'b1;
        o_dump_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_dump_addr = addr_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_mem_data, i_alu_result;
  logic        i_rf_wr_enb, i_rf_wr_data_src, i_valid;
  logic [4:0]  i_rf_wr_addr, i_rd_addr_a, i_rd_addr_b;
  logic [31:0] o_rd_data_a, o_rd_data_b, o_wb_data;
  logic [4:0]  o_wb_addr;
  logic        o_wb_enb;
  logic [31:0] o_retired_count;
  logic        i_dump_start, i_dump_ready;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_busy, o_dump_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  writeback_unit dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_mem_data(i_mem_data), .i_alu_result(i_alu_result),
    .i_rf_wr_enb(i_rf_wr_enb), .i_rf_wr_data_src(i_rf_wr_data_src),
    .i_rf_wr_addr(i_rf_wr_addr), .i_valid(i_valid),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
    .o_rd_data_a(o_rd_data_a), .o_rd_data_b(o_rd_data_b),
    .o_wb_data(o_wb_data), .o_wb_addr(o_wb_addr), .o_wb_enb(o_wb_enb),
    .o_retired_count(o_retired_count),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr),
    .o_dump_data(o_dump_data), .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1-2 time units after the rising edge
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic src, input logic [31:0] alu, input logic [31:0] mem);
    i_valid = 1'b1; i_rf_wr_enb = 1'b1; i_rf_wr_addr = addr;
    i_rf_wr_data_src = src; i_alu_result = alu; i_mem_data = mem;
    tick();
    i_valid = 1'b0; i_rf_wr_enb = 1'b0;
  endtask

  int k;
  int done_cnt;
  bit seen_end;
  logic [31:0] exp_rd;

  initial begin
    i_reset = 1'b1; i_mem_data = '0; i_alu_result = '0; i_rf_wr_enb = 1'b0;
    i_rf_wr_data_src = 1'b0; i_rf_wr_addr = '0; i_valid = 1'b0;
    i_rd_addr_a = 5'd5; i_rd_addr_b = 5'd31; i_dump_start = 1'b0; i_dump_ready = 1'b0;

    // Reset state
    tick(); #1;
    check("reset_rd_a5", o_rd_data_a, 32'h0);
    check("reset_rd_b31", o_rd_data_b, 32'h0);
    check("reset_retired", o_retired_count, 32'h0);
    check("reset_busy", {31'b0, o_dump_busy}, 32'h0);
    check("reset_valid", {31'b0, o_dump_valid}, 32'h0);
    i_reset = 1'b0;
    tick();

    // Retire counter: 10 valid (3 without write enable) + 4 bubbles
    for (int i = 0; i < 14; i++) begin
      i_valid = (i < 10);
      i_rf_wr_enb = (i < 10) && !(i == 2 || i == 5 || i == 8);
      i_rf_wr_addr = 5'd0;
      tick();
    end
    i_valid = 1'b0; i_rf_wr_enb = 1'b0; #1;
    check("retired_10", o_retired_count, 32'd10);

    // Write paths
    i_valid = 1'b1; i_rf_wr_enb = 1'b1; i_rf_wr_addr = 5'd7;
    i_rf_wr_data_src = 1'b0; i_alu_result = 32'h0000_00AA; i_mem_data = 32'h1111_1111; #1;
    check("wb_data_alu", o_wb_data, 32'h0000_00AA);
    check("wb_addr", {27'b0, o_wb_addr}, 32'd7);
    check("wb_enb_7", {31'b0, o_wb_enb}, 32'h1);
    tick(); i_valid = 1'b0; i_rf_wr_enb = 1'b0;
    i_rd_addr_a = 5'd7; #1;
    check("rd_a_7", o_rd_data_a, 32'h0000_00AA);

    wr(5'd8, 1'b1, 32'h2222_2222, 32'hDEAD_BEEF);
    i_rd_addr_b = 5'd8; #1;
    check("rd_b_8", o_rd_data_b, 32'hDEAD_BEEF);

    i_valid = 1'b1; i_rf_wr_enb = 1'b1; i_rf_wr_addr = 5'd0;
    i_rf_wr_data_src = 1'b0; i_alu_result = 32'h0000_1234; #1;
    check("wb_enb_r0", {31'b0, o_wb_enb}, 32'h0);
    tick(); i_valid = 1'b0; i_rf_wr_enb = 1'b0;
    i_rd_addr_a = 5'd0; #1;
    check("rd_r0", o_rd_data_a, 32'h0);

    // Bubble with write enable set must not write
    i_valid = 1'b0; i_rf_wr_enb = 1'b1; i_rf_wr_addr = 5'd10; i_alu_result = 32'h0000_0BAD; #1;
    check("wb_enb_bubble", {31'b0, o_wb_enb}, 32'h0);
    tick(); i_rf_wr_enb = 1'b0;
    i_rd_addr_a = 5'd10; #1;
    check("rd_bubble_10", o_rd_data_a, 32'h0);

    // Same-cycle read/write hazard
    wr(5'd9, 1'b0, 32'h0000_0001, 32'h0);
    i_valid = 1'b1; i_rf_wr_enb = 1'b1; i_rf_wr_addr = 5'd9;
    i_rf_wr_data_src = 1'b0; i_alu_result = 32'h0000_0055; i_rd_addr_a = 5'd9; #1;
`ifdef WB_BYPASS_EN
    exp_rd = 32'h0000_0055;
`else
    exp_rd = 32'h0000_0001;
`endif
    check("hazard_same_cycle", o_rd_data_a, exp_rd);
    tick(); i_valid = 1'b0; i_rf_wr_enb = 1'b0; #1;
    check("hazard_next_cycle", o_rd_data_a, 32'h0000_0055);

    // Dump with backpressure: preload rf[k] = k*3
    for (int r = 1; r < 32; r++) wr(r[4:0], 1'b0, r * 3, 32'h0);
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    k = 0; done_cnt = 0; seen_end = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_end; cyc++) begin
      i_dump_ready = (cyc % 2 == 1);
      #1;
      if (o_dump_valid) begin
        check("dump_addr", {27'b0, o_dump_addr}, k);
        check("dump_data", o_dump_data, k * 3);
        if (i_dump_ready) k++;
      end else if (o_dump_done) begin
        done_cnt++;
        check("dump_done_busy", {31'b0, o_dump_busy}, 32'h1);
      end else begin
        seen_end = 1'b1;
      end
      if (!seen_end) tick();
    end
    check("dump_word_count", k, 32);
    check("dump_done_pulses", done_cnt, 1);
    check("dump_idle_busy", {31'b0, o_dump_busy}, 32'h0);

    // Reset in the middle of a dump
    tick();
    i_dump_ready = 1'b1; i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    for (int cyc = 0; cyc < 50 && o_dump_addr != 5'd12; cyc++) tick();
    check("midreset_reached_12", {27'b0, o_dump_addr}, 32'd12);
    i_rd_addr_a = 5'd5; #1;
    check("midreset_pre_rd5", o_rd_data_a, 32'd15);
    #1 i_reset = 1'b1; #1;
    check("midreset_valid", {31'b0, o_dump_valid}, 32'h0);
    check("midreset_busy", {31'b0, o_dump_busy}, 32'h0);
    check("midreset_addr", {27'b0, o_dump_addr}, 32'h0);
    check("midreset_rd5", o_rd_data_a, 32'h0);
    check("midreset_retired", o_retired_count, 32'h0);
    tick();
    i_reset = 1'b0; i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0; #1;
    check("restart_valid", {31'b0, o_dump_valid}, 32'h1);
    check("restart_addr", {27'b0, o_dump_addr}, 32'h0);
    tick(); #1;
    check("restart_addr1", {27'b0, o_dump_addr}, 32'h1);
    check("restart_data1", o_dump_data, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Write-back (WB) stage of the 5-stage MIPS pipeline. It is the consuming end of the MEM/WB latch.
- Selects the register-file write data: latched memory read data or latched ALU result.
- Owns the 32x32 register file and serves the two ID-stage read ports.
- Exposes the WB write to EX forwarding.
- Counts retired instructions.
- Runs a handshaked register-file dump sequencer for the debug unit.

Parameters:
NB_ADDR, 5, register-file address width.
NB_DATA, 2**NB_ADDR, data width (32).
NB_RETIRE, 32, retired-instruction counter width.

Ports:
i_clock  in  1  system clock, all state on rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_mem_data  in  NB_DATA  latched data-memory read value (MEM/WB).
i_alu_result  in  NB_DATA  latched ALU result (MEM/WB).
i_rf_wr_enb  in  1  latched register-file write enable.
i_rf_wr_data_src  in  1  1 = write i_mem_data, 0 = write i_alu_result.
i_rf_wr_addr  in  NB_ADDR  latched destination register.
i_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble).
i_rd_addr_a / i_rd_addr_b  in  NB_ADDR  ID-stage read addresses.
o_rd_data_a / o_rd_data_b  out  NB_DATA  ID-stage read data.
o_wb_data  out  NB_DATA  selected write-back data (forwarding).
o_wb_addr  out  NB_ADDR  write-back destination (forwarding).
o_wb_enb  out  1  effective write (forwarding qualifier).
o_retired_count  out  NB_RETIRE  retired-instruction count.
i_dump_start  in  1  request full register-file dump.
i_dump_ready  in  1  debug consumer accepts current word.
o_dump_valid  out  1  dump word valid.
o_dump_addr  out  NB_ADDR  register index of dump word.
o_dump_data  out  NB_DATA  register contents.
o_dump_busy  out  1  sequencer not IDLE.
o_dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, any time including mid-dump):
  - All 32 registers cleared to 0; o_retired_count = 0.
  - FSM goes to IDLE; o_dump_valid, o_dump_busy, o_dump_done = 0; o_dump_addr = 0.
- Write-back data and forwarding:
  - o_wb_data = i_rf_wr_data_src ? i_mem_data : i_alu_result (combinational).
  - o_wb_enb = i_valid & i_rf_wr_enb & (i_rf_wr_addr != 0).
  - o_wb_addr = i_rf_wr_addr.
- Register write: on the rising edge when o_wb_enb = 1, rf[i_rf_wr_addr] <= o_wb_data. Register 0 is never written and always reads 0.
- Reads:
  - Combinational. Address 0 returns 0.
  - Same-cycle read/write hazard is governed by WB_BYPASS_EN (see Optional Feature).
- Retire counter: +1 on each edge with i_valid = 1, regardless of write enable. Saturates at 2**NB_RETIRE-1; no wrap.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE:
    - i_dump_start = 1 -> SEND, o_dump_addr = 0. Start is level-sampled.
    - i_dump_start is ignored in SEND and DONE.
  - SEND:
    - o_dump_valid = 1, o_dump_busy = 1; o_dump_data = rf[o_dump_addr] (combinational, live contents).
    - Valid is held and addr/data stay stable until i_dump_ready = 1.
    - On an accepted word with addr < 31: addr + 1, stay in SEND.
    - On an accepted word with addr = 31: -> DONE.
  - DONE:
    - o_dump_done = 1 and o_dump_busy = 1 for exactly one cycle; o_dump_valid = 0.
    - Then -> IDLE with addr = 0.
  - Dump of 32 words with ready held high takes 32 cycles in SEND plus 1 in DONE.
  - Writes during a dump are permitted. A word reflects the register value at its acceptance edge.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when o_wb_enb = 1 and i_rd_addr_x == i_rf_wr_addr (nonzero), o_rd_data_x = o_wb_data in the same cycle (write-through). This also applies to o_dump_data when o_dump_addr matches.
- Undefined: reads return the pre-write stored value. The hazard unit must stall ID one extra cycle for this case.

Test Plan:
- Reset then read: assert i_reset, read a = 5, b = 31 -> both 0, o_retired_count = 0, o_dump_busy = 0.
- Write paths:
  - Write addr 7, src 0, alu 0x0000_00AA -> next cycle rd_a(7) = 0xAA.
  - Write addr 8, src 1, mem 0xDEAD_BEEF -> rd_b(8) = 0xDEADBEEF.
  - Write addr 0, value 0x1234 -> rd(0) = 0 and o_wb_enb = 0.
- Same-cycle hazard: rf[9] = 0x1, write 9 <= 0x55 with read a = 9 in the same cycle -> 0x55 if WB_BYPASS_EN, else 0x1. Next cycle 0x55 in both builds.
- Retire counter: 10 cycles with i_valid = 1 including 3 with i_rf_wr_enb = 0, plus 4 bubbles -> o_retired_count = 10.
- Dump with backpressure: preload rf[k] = k*3, pulse start, toggle ready every other cycle -> 32 words, addr 0..31, data k*3. Addr and data stay stable while ready = 0. o_dump_done pulses once, then busy = 0.
- Reset mid-dump: assert i_reset at addr = 12 -> valid = 0, busy = 0, registers = 0. A new start restarts at addr 0.
